// File: rtl/bcd_add_sequencer.sv
// bcd_add_sequencer: multi-digit BCD adder controller. One external
// single-digit BCD adder is reused across DIGITS positions, least-significant
// digit first. Operands are checked for invalid nibbles before any addition.
//
// Handshake: the requester pulses start while the block is idle (busy=0,
// done=0). start is sampled only in IDLE and ignored in every other state.
// busy stays high while work is in progress (CHECK, ADD). done is a single
// cycle pulse. result/cout/err are valid from the done cycle and hold until
// the next accepted start. Operand inputs are latched when start is accepted
// and may change freely afterwards.
module bcd_add_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   op_a,
    input  logic [4*DIGITS-1:0]   op_b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err,
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_sum,
    input  logic                  dig_cout,
    output logic [1:0]            state_dbg
);

    localparam int IW = $clog2(DIGITS) + 1;
    localparam int SW = (IW > 2) ? IW : 2;

    typedef enum logic [SW-1:0] {
        IDLE,
        CHECK,
        ADD,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q;
    logic                  carry_q;
    logic                  cin_q;
    logic [4*DIGITS-1:0]   a_q, b_q;
    logic [4*DIGITS-1:0]   result_q;
    logic                  cout_q;
    logic                  err_q;

    logic                  operands_bad;
    logic [3:0]            cur_a, cur_b;
    logic                  last_digit;

    assign busy      = (state_q == CHECK) || (state_q == ADD);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign err       = err_q;
    assign state_dbg = state_q[1:0];
    assign last_digit = (idx_q == IW'(DIGITS - 1));

    // Flag any latched nibble of either operand above 9.
    always_comb begin
        operands_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a_q[i*4 +: 4] > 4'd9) || (b_q[i*4 +: 4] > 4'd9)) begin
                operands_bad = 1'b1;
            end
        end
    end

    // Select the operand digits addressed by idx.
    always_comb begin
        cur_a = 4'd0;
        cur_b = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_a = a_q[i*4 +: 4];
                cur_b = b_q[i*4 +: 4];
            end
        end
    end

    // Drive the shared adder only in ADD; the carry comes from a register,
    // so there is no combinational path from dig_cout back to dig_cin.
    always_comb begin
        dig_a   = 4'd0;
        dig_b   = 4'd0;
        dig_cin = 1'b0;
        if (state_q == ADD) begin
            dig_a   = cur_a;
            dig_b   = cur_b;
            dig_cin = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = operands_bad ? DONE : ADD;
            ADD:     if (last_digit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, digit index, ripple carry and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        cin_q    <= cin;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        err_q    <= 1'b0;
                        idx_q    <= '0;
                        carry_q  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (operands_bad) begin
                        err_q <= 1'b1;
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IW'(i)) begin
                            result_q[i*4 +: 4] <= dig_sum;
                        end
                    end
                    carry_q <= dig_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (last_digit) begin
                        cout_q <= dig_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Testbench for bcd_add_sequencer with DIGITS=4 and a behavioural
// single-digit BCD adder on the dig_* interface.
module tb_bcd_add_sequencer;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a, op_b;
    logic          cin;
    logic          busy, done, cout, err;
    logic [W-1:0]  result;
    logic [3:0]    dig_a, dig_b, dig_sum;
    logic          dig_cin, dig_cout;
    logic [1:0]    state_dbg;

    bcd_add_sequencer #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .err(err),
        .dig_a(dig_a), .dig_b(dig_b), .dig_cin(dig_cin),
        .dig_sum(dig_sum), .dig_cout(dig_cout), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Shared single-digit BCD adder.
    always_comb begin
        int s;
        s = int'(dig_a) + int'(dig_b) + int'(dig_cin);
        if (s > 9) begin
            dig_sum  = 4'(s - 10);
            dig_cout = 1'b1;
        end else begin
            dig_sum  = 4'(s);
            dig_cout = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    logic [3:0] tr_a[0:19];
    logic [3:0] tr_b[0:19];
    logic       tr_cin[0:19];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
        logic         co;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal-arithmetic reference model.
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, output logic [W-1:0] r,
                                      output logic co, output logic e);
        int va, vb, p, tot, da, db;
        va = 0; vb = 0; p = 1; e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            da = int'(a[i*4 +: 4]);
            db = int'(b[i*4 +: 4]);
            if (da > 9 || db > 9) e = 1'b1;
            va += da * p;
            vb += db * p;
            p  *= 10;
        end
        r = '0;
        co = 1'b0;
        if (!e) begin
            tot = va + vb + int'(c);
            co  = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < DIGITS; i++) begin
                r[i*4 +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end
    endfunction

    // Driver: issue one operation, trace the adder interface, check timing.
    // Returns one cycle after done (block back in IDLE).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic hold_start, input int exp_lat);
        int n;
        logic busy_ok;
        logic [3:0] da, db;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        busy_ok = 1'b1;
        n = 1;
        while (n < 20 && !done) begin
            tr_a[n] = dig_a; tr_b[n] = dig_b; tr_cin[n] = dig_cin;
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, exp_lat);
        check("busy_while_active", busy_ok, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("dig_zero_at_done", {dig_a, dig_b, dig_cin}, 9'd0);
        check("dig_zero_in_check", {tr_a[1], tr_b[1], tr_cin[1]}, 9'd0);
        if (exp_lat == DIGITS + 2 && n == exp_lat) begin
            for (int k = 2; k <= DIGITS + 1; k++) begin
                da = a[(k-2)*4 +: 4];
                db = b[(k-2)*4 +: 4];
                check("dig_a_add", tr_a[k], da);
                check("dig_b_add", tr_b[k], db);
            end
            check("dig_cin_first", tr_cin[2], c);
        end
        @(posedge clk); #1;
        if (hold_start) start = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b, r, held;
        logic co, e, saw_done;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 6};
        vecs[1] = '{16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 6};
        vecs[2] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 6};
        vecs[3] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 6};
        vecs[4] = '{16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 2};
        vecs[5] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 6};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 6};
        vecs[7] = '{16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1, 2};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 16'h0000);
        check("reset_cout_err", {cout, err}, 2'b00);
        check("reset_dig", {dig_a, dig_b, dig_cin}, 9'd0);
        repeat (2) @(posedge clk);
        #1 check("idle_without_start", busy, 1'b0);

        // Table vectors, issued back to back.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].lat);
            check("vec_result", result, vecs[i].r);
            check("vec_cout", cout, vecs[i].co);
            check("vec_err", err, vecs[i].e);
            if (i == 0) begin
                check("dig_a_seq0", tr_a[2], 4'd4);
                check("dig_a_seq1", tr_a[3], 4'd3);
                check("dig_a_seq2", tr_a[4], 4'd2);
                check("dig_a_seq3", tr_a[5], 4'd1);
            end
            if (i == 1) begin
                check("dig_cin_seq", {tr_cin[2], tr_cin[3], tr_cin[4], tr_cin[5]}, 4'b1111);
            end
        end

        // start held through busy and DONE: exactly one operation.
        run_op(16'h0123, 16'h0456, 1'b0, 1'b1, 6);
        check("hold_result", result, 16'h0579);
        held = result;
        repeat (2) @(posedge clk);
        #1;
        check("hold_no_restart", busy, 1'b0);
        check("hold_result_kept", result, held);

        // Reset during ADD at idx=2.
        op_a = 16'h1234; op_b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid_add_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_result", result, 16'h0000);
        check("abort_cout_err", {cout, err}, 2'b00);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", saw_done, 1'b0);
        run_op(16'h4321, 16'h1111, 1'b1, 1'b0, 6);
        check("after_abort_result", result, 16'h5433);
        check("after_abort_cout", cout, 1'b0);

        // Randomized operations against the decimal model.
        for (int t = 0; t < 150; t++) begin
            for (int d = 0; d < DIGITS; d++) begin
                a[d*4 +: 4] = 4'($urandom_range(0, 9));
                b[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 99) < 15) begin
                if ($urandom_range(0, 1) == 0)
                    a[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
                else
                    b[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
            end
            cin = 1'($urandom_range(0, 1));
            ref_model(a, b, cin, r, co, e);
            exp_q.push_back(r);
            run_op(a, b, cin, 1'b0, e ? 2 : DIGITS + 2);
            check("rand_result", result, exp_q.pop_front());
            check("rand_cout", cout, co);
            check("rand_err", err, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
